// File: rtl/circle_intersections_pkg.sv
// Shared widths, output field offsets and FSM state encoding for circle_intersections.
// All widths are derived from the coordinate width N via constant functions.
package circle_intersections_pkg;

  localparam int unsigned DefaultN = 8;

  function automatic int unsigned rad_w(input int unsigned n);  return n + 1;       endfunction
  function automatic int unsigned diff_w(input int unsigned n); return n + 1;       endfunction
  function automatic int unsigned d_w(input int unsigned n);    return 2 * n + 3;   endfunction
  function automatic int unsigned k_w(input int unsigned n);    return 2 * n + 4;   endfunction
  function automatic int unsigned disc_w(input int unsigned n); return 4 * n + 10;  endfunction
  function automatic int unsigned root_w(input int unsigned n); return 2 * n + 5;   endfunction
  function automatic int unsigned xo_w(input int unsigned n);   return 4 * n + 10;  endfunction
  function automatic int unsigned yo_w(input int unsigned n);   return 3 * n + 7;   endfunction
  function automatic int unsigned o_w(input int unsigned n);    return 14 * n + 34; endfunction

  function automatic int unsigned x1_lsb(input int unsigned n); return 10 * n + 24; endfunction
  function automatic int unsigned y1_lsb(input int unsigned n); return 7 * n + 17;  endfunction
  function automatic int unsigned x2_lsb(input int unsigned n); return 3 * n + 7;   endfunction
  function automatic int unsigned y2_lsb(input int unsigned n); return 0;           endfunction

  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StPrep = 3'd1;
  localparam state_t StDisc = 3'd2;
  localparam state_t StSqrt = 3'd3;
  localparam state_t StOut  = 3'd4;

endpackage

// File: rtl/isqrt_seq.sv
// Restoring bit-serial floor square root, one root bit per cycle, RootW cycles total.
// The first bit is resolved on the start edge itself so done follows RootW-1 edges later.
module isqrt_seq #(
  parameter int unsigned RootW = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*RootW-1:0]   radicand,
  output logic [RootW-1:0]     root,
  output logic                 done
);
  localparam int unsigned RadW = 2 * RootW;
  localparam int unsigned RemW = RootW + 1;
  localparam int unsigned CntW = $clog2(RootW + 1);

  logic [RadW-1:0]  rad_q, rad_in, rad_nx;
  logic [RemW-1:0]  rem_q, rem_in, rem_nx;
  logic [RootW-1:0] root_q, root_in, root_nx;
  logic [RemW+1:0]  rem_sh, trial;
  logic [CntW-1:0]  cnt_q;
  logic             active_q, done_q, fits;

  always_comb begin
    rad_in  = start ? radicand : rad_q;
    rem_in  = start ? '0 : rem_q;
    root_in = start ? '0 : root_q;
    rem_sh  = {rem_in, rad_in[RadW-1 -: 2]};
    trial   = {1'b0, root_in, 2'b01};
    fits    = (rem_sh >= trial);
    rem_nx  = RemW'(fits ? rem_sh - trial : rem_sh);
    root_nx = {root_in[RootW-2:0], fits};
    rad_nx  = {rad_in[RadW-3:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rad_q    <= rad_nx;
        rem_q    <= rem_nx;
        root_q   <= root_nx;
        cnt_q    <= CntW'(1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rad_q  <= rad_nx;
        rem_q  <= rem_nx;
        root_q <= root_nx;
        cnt_q  <= cnt_q + CntW'(1);
        if (cnt_q == CntW'(RootW - 1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign root = root_q;
  assign done = done_q;

endmodule

// File: rtl/circle_intersections.sv
// Exact, division-free intersection points of two circles as numerators over 2*D.
// Optional INTERSECTIONS_NOSOL_EN adds a no_sol flag for disjoint or concentric circles.
module circle_intersections
  import circle_intersections_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3*N:0]      g_input,
  input  logic [3*N:0]      e_input,
  output logic [14*N+33:0]  o,
  output logic              done,
  output logic              busy
`ifdef INTERSECTIONS_NOSOL_EN
  ,
  output logic              no_sol
`endif
);
  localparam int unsigned DiffW = diff_w(N);
  localparam int unsigned DW    = d_w(N);
  localparam int unsigned KW    = k_w(N);
  localparam int unsigned DiscW = disc_w(N);
  localparam int unsigned RootW = root_w(N);
  localparam int unsigned XW    = xo_w(N);
  localparam int unsigned YW    = yo_w(N);
  localparam int unsigned OW    = o_w(N);
  localparam int unsigned R2W   = 2 * rad_w(N);

  state_t                   state_q;
  logic [3*N:0]             g_q, e_q;
  logic signed [DiffW-1:0]  dx_q, dy_q, dx_c, dy_c;
  logic [DW-1:0]            d_q, d_c, dxw, dyw;
  logic signed [KW-1:0]     k_q, k_c;
  logic [OW-1:0]            o_q, o_c;
  logic                     done_q;

  logic signed [N-1:0]      xb, yb, xc, yc;
  logic [N:0]               rb, rc;
  logic [R2W-1:0]           rb2, rc2;

  assign xb = g_q[3*N -: N];
  assign yb = g_q[2*N -: N];
  assign rb = g_q[N:0];
  assign xc = e_q[3*N -: N];
  assign yc = e_q[2*N -: N];
  assign rc = e_q[N:0];
  assign rb2 = R2W'(rb) * R2W'(rb);
  assign rc2 = R2W'(rc) * R2W'(rc);

  // Squares are exact modulo 2^DW, so sign-extended DW-bit products suffice.
  assign dx_c = DiffW'(xc) - DiffW'(xb);
  assign dy_c = DiffW'(yc) - DiffW'(yb);
  assign dxw  = DW'(dx_c);
  assign dyw  = DW'(dy_c);
  assign d_c  = dxw * dxw + dyw * dyw;
  assign k_c  = $signed(KW'(d_c)) + $signed(KW'(rb2)) - $signed(KW'(rc2));

  logic [DiscW-1:0]         rd, radicand;
  logic signed [DiscW-1:0]  k_e, disc_c;
  logic [RootW-1:0]         root;
  logic                     sq_start, sq_done;

  assign rd       = DiscW'(rb2) * DiscW'(d_q);
  assign k_e      = DiscW'(k_q);
  assign disc_c   = $signed(rd << 2) - k_e * k_e;
  assign radicand = disc_c[DiscW-1] ? '0 : disc_c;
  assign sq_start = (state_q == StDisc);

  isqrt_seq #(
    .RootW(RootW)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (sq_start),
    .radicand(radicand),
    .root    (root),
    .done    (sq_done)
  );

  logic signed [XW-1:0] dx_x, dy_x, k_x, s_x, d2_x, xb_x, base_x, x1, x2;
  logic signed [YW-1:0] dx_y, dy_y, k_y, s_y, d2_y, yb_y, base_y, y1, y2;

  always_comb begin
    dx_x   = XW'(dx_q);
    dy_x   = XW'(dy_q);
    k_x    = XW'(k_q);
    s_x    = $signed(XW'(root));
    d2_x   = $signed(XW'(d_q)) <<< 1;
    xb_x   = XW'(xb);
    base_x = d2_x * xb_x + k_x * dx_x;
    x1     = base_x - s_x * dy_x;
    x2     = base_x + s_x * dy_x;
    dx_y   = YW'(dx_q);
    dy_y   = YW'(dy_q);
    k_y    = YW'(k_q);
    s_y    = $signed(YW'(root));
    d2_y   = $signed(YW'(d_q)) <<< 1;
    yb_y   = YW'(yb);
    base_y = d2_y * yb_y + k_y * dy_y;
    y1     = base_y + s_y * dx_y;
    y2     = base_y - s_y * dx_y;
    o_c    = '0;
    o_c[x1_lsb(N) +: XW] = x1;
    o_c[y1_lsb(N) +: YW] = y1;
    o_c[x2_lsb(N) +: XW] = x2;
    o_c[y2_lsb(N) +: YW] = y2;
  end

`ifdef INTERSECTIONS_NOSOL_EN
  logic disc_neg_q, no_sol_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      e_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      d_q     <= '0;
      k_q     <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
`ifdef INTERSECTIONS_NOSOL_EN
      disc_neg_q <= 1'b0;
      no_sol_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            g_q     <= g_input;
            e_q     <= e_input;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          dx_q    <= dx_c;
          dy_q    <= dy_c;
          d_q     <= d_c;
          k_q     <= k_c;
          state_q <= StDisc;
        end
        StDisc: begin
`ifdef INTERSECTIONS_NOSOL_EN
          disc_neg_q <= disc_c[DiscW-1];
`endif
          state_q <= StSqrt;
        end
        StSqrt: begin
          if (sq_done) state_q <= StOut;
        end
        StOut: begin
          o_q     <= o_c;
          done_q  <= 1'b1;
`ifdef INTERSECTIONS_NOSOL_EN
          no_sol_q <= disc_neg_q || (d_q == '0);
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o    = o_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);
`ifdef INTERSECTIONS_NOSOL_EN
  assign no_sol = no_sol_q;
`endif

endmodule

// File: tb/tb_circle_intersections.sv
// Directed, table-driven bench for circle_intersections at N=8.
module tb_circle_intersections;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [3*N:0]      g_input, e_input;
  logic [14*N+33:0]  o;
  logic              done, busy;
`ifdef INTERSECTIONS_NOSOL_EN
  logic              no_sol;
`endif

  always #5 clk = ~clk;

  circle_intersections #(
    .N(N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .g_input(g_input),
    .e_input(e_input),
    .o      (o),
    .done   (done),
    .busy   (busy)
`ifdef INTERSECTIONS_NOSOL_EN
    ,
    .no_sol (no_sol)
`endif
  );

  typedef struct {
    logic [24:0] g;
    logic [24:0] e;
    longint      x1;
    longint      y1;
    longint      x2;
    longint      y2;
    logic        ns;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [24:0] circ(input int x, input int y, input int r);
    logic [24:0] v;
    v = {x[7:0], y[7:0], r[8:0]};
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic launch(input logic [24:0] g, input logic [24:0] e);
    @(negedge clk);
    g_input = g;
    e_input = e;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n counts edges since the accepting edge; 100 means no done appeared
  task automatic wait_done(inout int n);
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    logic signed [41:0] x1, x2;
    logic signed [30:0] y1, y2;
    x1 = o[145:104];
    y1 = o[103:73];
    x2 = o[72:31];
    y2 = o[30:0];
    check({tag, ".x1"}, x1, v.x1);
    check({tag, ".y1"}, y1, v.y1);
    check({tag, ".x2"}, x2, v.x2);
    check({tag, ".y2"}, y2, v.y2);
`ifdef INTERSECTIONS_NOSOL_EN
    check({tag, ".no_sol"}, no_sol, v.ns);
`endif
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{circ(0, 0, 5), circ(8, 0, 5), 512, 384, 512, -384, 1'b0};
    vecs[1] = '{circ(-32, 108, 215), circ(-16, -111, 236),
                16390824, 3307162, -21322728, 551834, 1'b0};
    vecs[2] = '{circ(0, 0, 3), circ(6, 0, 3), 216, 0, 216, 0, 1'b0};
    vecs[3] = '{circ(0, 0, 1), circ(10, 0, 1), 1000, 0, 1000, 0, 1'b1};
    vecs[4] = '{circ(5, 5, 3), circ(5, 5, 4), 0, 0, 0, 0, 1'b1};
    vecs[5] = '{circ(0, 0, 5), circ(0, 8, 5), -384, 512, 384, 512, 1'b0};
    vecs[6] = '{circ(10, 20, 5), circ(18, 20, 5), 1792, 2944, 1792, 2176, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    g_input = '0;
    e_input = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("reset.o_nonzero", longint'(o != '0), 0);
    check("reset.done", done, 0);
    check("reset.busy", busy, 0);
    check("reset.done_seen", seen, 0);
`ifdef INTERSECTIONS_NOSOL_EN
    check("reset.no_sol", no_sol, 0);
`endif

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].g, vecs[i].e);
      check($sformatf("v%0d.busy", i), busy, 1);
      n = 0;
      wait_done(n);
      check($sformatf("v%0d.latency", i), n, 24);
      check_result($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // A second start while busy must not disturb or repeat the running job
    launch(vecs[0].g, vecs[0].e);
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    g_input = vecs[1].g;
    e_input = vecs[1].e;
    start = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start = 1'b0;
    wait_done(n);
    check("busy_start.latency", n, 24);
    check_result("busy_start", vecs[0]);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("busy_start.extra_done", seen, 0);

    // start held high: results every 25 cycles
    @(negedge clk);
    g_input = vecs[2].g;
    e_input = vecs[2].e;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    wait_done(n);
    check("b2b.first", n, 24);
    wait_done(n);
    start = 1'b0;
    check("b2b.second", n, 49);
    check_result("b2b", vecs[2]);

    // Reset in the middle of the square-root phase aborts the job
    check("abort.o_before", longint'(o != '0), 1);
    launch(vecs[1].g, vecs[1].e);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check("abort.done_seen", seen, 0);
    check("abort.o_nonzero", longint'(o != '0), 0);
    check("abort.busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
